// File: rtl/mem_wb_skid_buffer.sv
// Two-entry mem/wb skid buffer: formats load data and stamps RVFI commit order at enqueue.
// Optional perf counters are enabled with the MEM_WB_PERF_EN macro.

package mem_wb_pkg;

    typedef struct packed {
        logic       mem_read_d;
        logic       mem_write_d;
        logic [2:0] load_funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic        load_regfile;
        logic [3:0]  regfilemux_sel;
        logic [4:0]  rd;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid_commit;
        logic [63:0] order_commit;
        logic [31:0] pc_rdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
    } rvfi_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
        rvfi_t     rvfi;
    } control_word;

endpackage

module mem_wb_skid_buffer
    import mem_wb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ORDER_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_rdy,
    input  logic [31:0] alu_out_in,
    input  logic        br_en_in,
    input  logic [31:0] u_imm_in,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] mem_addr,
    input  control_word cw_in,
    input  logic        wb_ready,
    output logic        mem_wb_valid,
    output logic [31:0] alu_out,
    output logic        br_en,
    output logic [31:0] ir_u_imm,
    output logic [31:0] mem_data_out,
    output control_word cw_out
`ifdef MEM_WB_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_commits
`endif
);

    typedef struct packed {
        logic [31:0] alu;
        logic        br_en;
        logic [31:0] u_imm;
        logic [31:0] mdata;
        control_word cw;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    entry_t               main_q;
    entry_t               skid_q;
    entry_t               in_e;
    logic [ORDER_W-1:0]   order_q;
    logic                 enq;
    logic                 deq;

    function automatic entry_t reset_entry();
        entry_t e;
        e                  = '0;
        e.cw.rvfi.pc_rdata = 32'h4000_0000;
        return e;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = d;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    // mem_rdy depends only on registered state, so wb_ready never reaches it combinationally.
    assign mem_rdy      = (state != FULL);
    assign mem_wb_valid = (state != EMPTY);
    assign enq          = mem_valid && mem_rdy;
    assign deq          = mem_wb_valid && wb_ready;

    always_comb begin
        in_e                      = '0;
        in_e.alu                  = alu_out_in;
        in_e.br_en                = br_en_in;
        in_e.u_imm                = u_imm_in;
        in_e.mdata                = cw_in.mem.mem_read_d
                                  ? fmt_load(cw_in.mem.load_funct3, mem_addr[1:0], dmem_rdata)
                                  : 32'd0;
        in_e.cw                   = cw_in;
        in_e.cw.rvfi.mem_rdata    = dmem_rdata;
        in_e.cw.rvfi.mem_addr     = mem_addr;
        in_e.cw.rvfi.order_commit = cw_in.rvfi.valid_commit ? 64'(order_q) : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            main_q  <= reset_entry();
            skid_q  <= reset_entry();
            order_q <= '0;
        end else begin
            if (enq && cw_in.rvfi.valid_commit)
                order_q <= order_q + 1'b1;
            case (state)
                EMPTY: begin
                    if (enq) begin
                        main_q <= in_e;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (enq && deq) begin
                        main_q <= in_e;
                    end else if (enq) begin
                        skid_q <= in_e;
                        state  <= FULL;
                    end else if (deq) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (deq) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign alu_out      = main_q.alu;
    assign br_en        = main_q.br_en;
    assign ir_u_imm     = main_q.u_imm;
    assign mem_data_out = main_q.mdata;
    assign cw_out       = main_q.cw;

`ifdef MEM_WB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_commits      <= '0;
        end else begin
            if (mem_wb_valid && !wb_ready && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (deq && main_q.cw.rvfi.valid_commit && perf_commits != 32'hFFFF_FFFF)
                perf_commits <= perf_commits + 32'd1;
        end
    end
`endif

endmodule
